// File: rtl/spi_master_parallel.sv
// spi_master_parallel
// ----------------------------------------------------------------------------
// SPI master for the parallel-word SPI link, used on the MIPS debug path
// between the host/debug controller and the parallel SPI slave.
//
// A start request launches one transfer:
//   - chip select rises and the latched word is driven on o_MOSI,
//   - after SETUP_CYCLES clocks one SCLK pulse (HALF_PERIOD high, HALF_PERIOD low)
//     is produced,
//   - the slave's parallel word is sampled when SCLK falls,
//   - that word is returned on o_data with a one-cycle o_valid strobe.
//
// Ports
//   i_clk    system clock, rising edge
//   i_rst    synchronous reset, active-high
//   i_start  transfer request, accepted only while idle
//   i_data   word to transmit, latched when the start is accepted
//   i_MISO   parallel word from the slave
//   o_MOSI   parallel word to the slave, zero outside a transfer
//   o_SCLK   SPI clock to the slave
//   o_cs     chip select, active-high
//   o_data   last received word, held until the next completion
//   o_valid  one-cycle pulse when o_data is updated
//   o_busy   high whenever a transfer is in progress (including DONE)
// ----------------------------------------------------------------------------
module spi_master_parallel #(
    parameter int NB_BITS      = 32,
    parameter int SETUP_CYCLES = 5,
    parameter int HALF_PERIOD  = 5,
    parameter int NB_CNT       = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_BITS-1:0] i_data,
    input  logic [NB_BITS-1:0] i_MISO,
    output logic [NB_BITS-1:0] o_MOSI,
    output logic               o_SCLK,
    output logic               o_cs,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_valid,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCLK_HIGH,
        SCLK_LOW,
        DONE
    } state_t;

    // The counter is loaded with (duration - 1) on state entry and the state
    // is left on the edge where it reads zero, so a state lasts exactly
    // "duration" cycles.
    localparam logic [NB_CNT-1:0] SETUP_LOAD = NB_CNT'(SETUP_CYCLES - 1);
    localparam logic [NB_CNT-1:0] HALF_LOAD  = NB_CNT'(HALF_PERIOD - 1);

    state_t             state;
    logic [NB_CNT-1:0]  cnt;
    logic [NB_BITS-1:0] rx;

    // NOTE: state and outputs live in one clocked block using non-blocking
    // assignments only; every output is a register and there is no
    // combinational next-state logic that could infer a latch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rx      <= '0;
            o_MOSI  <= '0;
            o_SCLK  <= 1'b0;
            o_cs    <= 1'b0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            // o_valid is a strobe: it is only raised on the completion edge.
            o_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_MOSI <= i_data;
                        o_cs   <= 1'b1;
                        o_busy <= 1'b1;
                        cnt    <= SETUP_LOAD;
                        state  <= SETUP;
                    end
                end

                SETUP: begin
                    if (cnt == '0) begin
                        o_SCLK <= 1'b1;
                        cnt    <= HALF_LOAD;
                        state  <= SCLK_HIGH;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SCLK_HIGH: begin
                    if (cnt == '0) begin
                        // Sample the slave word on the SCLK falling edge;
                        // it has had a full high phase to settle.
                        rx     <= i_MISO;
                        o_SCLK <= 1'b0;
                        cnt    <= HALF_LOAD;
                        state  <= SCLK_LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                SCLK_LOW: begin
                    if (cnt == '0) begin
                        o_cs    <= 1'b0;
                        o_MOSI  <= '0;
                        o_data  <= rx;
                        o_valid <= 1'b1;
                        cnt     <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    // One-cycle gap so back-to-back transfers always show
                    // chip select low for at least one idle cycle.
                    o_busy <= 1'b0;
                    cnt    <= '0;
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_master_parallel.md
Name: spi_master_parallel

Overview:
- SPI master for the parallel-word SPI link; the counterpart of the team's parallel SPI slave.
- Host pulses a start request with an NB_BITS word. The block then:
  - asserts chip select,
  - drives the word on the parallel MOSI bus,
  - generates one SCLK pulse derived from i_clk,
  - captures the slave's parallel MISO word and returns it to the host with a valid strobe.
- Sits between the debug/host controller and the SPI slave in the MIPS debug path.

Parameters:
NB_BITS, 32, width of MOSI/MISO/data words
SETUP_CYCLES, 5, i_clk cycles chip select is held with SCLK low before the SCLK rising edge (>=1)
HALF_PERIOD, 5, i_clk cycles per SCLK half period (>=1; 5 gives 100 ns SCLK at 100 MHz)
NB_CNT, 8, width of the internal phase counter (must hold max(SETUP_CYCLES, HALF_PERIOD))

Ports:
i_clk  in  1  system clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_start  in  1  transfer request; accepted only in IDLE
i_data  in  NB_BITS  word to transmit; latched when start is accepted
i_MISO  in  NB_BITS  parallel word from slave
o_MOSI  out  NB_BITS  parallel word to slave; zero outside a transfer
o_SCLK  out  1  SPI clock to slave
o_cs  out  1  chip select, active-high
o_data  out  NB_BITS  last received word; held until next completion
o_valid  out  1  one-cycle pulse when o_data is updated
o_busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Single clock domain. All outputs are registered. Reset is synchronous.
- Reset values: o_MOSI=0, o_SCLK=0, o_cs=0, o_data=0, o_valid=0, o_busy=0; FSM=IDLE; counter=0.
- FSM states: IDLE, SETUP, SCLK_HIGH, SCLK_LOW, DONE.
- Timing is counted in edges, where edge 0 is the i_clk edge that samples i_start=1 in IDLE.
- IDLE:
  - Outputs: o_cs=0, o_SCLK=0, o_MOSI=0.
  - At edge 0: latch i_data into o_MOSI; set o_cs=1, o_busy=1; go to SETUP.
- SETUP:
  - Lasts SETUP_CYCLES cycles.
  - At edge SETUP_CYCLES: o_SCLK=1; go to SCLK_HIGH.
- SCLK_HIGH:
  - Lasts HALF_PERIOD cycles.
  - At edge SETUP_CYCLES+HALF_PERIOD: capture i_MISO into the internal rx register, o_SCLK=0; go to SCLK_LOW.
  - The captured value is the one present just before that edge.
- SCLK_LOW:
  - Lasts HALF_PERIOD cycles.
  - At edge T=SETUP_CYCLES+2*HALF_PERIOD: o_cs=0, o_MOSI=0, o_data=rx, o_valid=1; go to DONE.
- DONE:
  - Lasts one cycle.
  - At edge T+1: o_valid=0, o_busy=0; go to IDLE.
- Defaults: o_cs high for 15 cycles, o_valid at edge 15, o_busy low after edge 16.
- Earliest next accepted start is edge T+2; back-to-back transfers leave >=1 IDLE cycle with o_cs=0.
- i_start while busy (including DONE) is ignored; it is not queued.
- i_start held high continuously gives repeated transfers, one per T+2 cycles.
- i_data changes after edge 0 do not affect o_MOSI during the transfer.
- i_MISO changes outside the capture edge have no effect.
- o_data changes only at completion; it is stable otherwise.
- Reset mid-transfer (any state):
  - Next edge forces all reset values and IDLE.
  - No o_valid is produced; o_data is cleared to 0.
  - i_rst wins over a simultaneous i_start.
- Counter: NB_CNT bits, reloaded on each state entry, no wrap behaviour exposed.
- Exactly one SCLK rising edge and one falling edge per transfer, both inside o_cs high.

Test Plan:
1. Reset held 3 cycles, then released -> all outputs 0; o_busy=0; no SCLK toggling for 20 cycles with i_start=0.
2. Defaults, i_data=32'hAAAAAAAA, slave model drives i_MISO=32'hA0000005 while o_cs=1:
   - o_cs rises after edge 0; o_MOSI=AAAAAAAA.
   - o_SCLK high on edges 5..10.
   - o_valid pulse at edge 15 with o_data=A0000005.
   - o_busy=0 after edge 16.
3. i_data changed to 32'h12345678 at edge 3, and i_start pulsed at edges 4 and 15 -> o_MOSI stays AAAAAAAA; no second transfer; o_valid pulses exactly once.
4. i_start held high for 40 cycles, i_MISO=32'h00000001 then 32'h00000002 -> two transfers:
   - o_valid at edges 15 and 32;
   - o_data 1 then 2;
   - o_cs low at edge 16.
5. i_rst asserted at edge 8 (SCLK high) -> at edge 9 o_SCLK=0, o_cs=0, o_MOSI=0, o_data=0, o_busy=0; no o_valid afterwards.
6. SETUP_CYCLES=1, HALF_PERIOD=1, i_MISO=32'hDEADBEEF -> o_SCLK high exactly 1 cycle; o_valid at edge 3 with o_data=DEADBEEF.
